vram_dbuf: RTL

- Single-clock, double-buffered frame memory for captured LCD pixels.
- The capture path writes one frame into the back bank.
- The scanout path reads the front bank.
- A completed frame is promoted to the front bank only during reader blanking, so scanout never shows a torn frame.
- Adds bank swap, frame-drop accounting and a hardware back-bank clear, on top of plain write/read pixel storage.

---
 rtl/vram_pkg.sv | 13 +
 rtl/vram_dbuf_dp1.sv | 33 +++
 rtl/vram_dbuf.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared encodings for the double-buffered frame memory.
package vram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLEAR   = 2'd2
   } vram_state_t;

   localparam int unsigned DROP_W = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/vram_dbuf_dp1.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module vram_dp1 #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Array has no reset so it can map onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_dbuf.sv
// Double-buffered frame memory: capture writes the back bank, scanout reads the
// front bank, and finished frames are promoted only during reader blanking.
module vram_dbuf
   import vram_pkg::*;
#(
   parameter int unsigned   AW        = 15,
   parameter int unsigned   DW        = 2,
   parameter logic [DW-1:0] CLEAR_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [AW-1:0]     i_wr_address,
   input  logic [DW-1:0]     i_data,
   input  logic              i_we,
   input  logic              i_wr_frame_end,
   input  logic              i_clear,
   input  logic [AW-1:0]     i_rd_address,
   input  logic              i_rd_en,
   input  logic              i_rd_vblank,
   output logic [DW-1:0]     o_q,
   output logic              o_q_valid,
   output logic              o_front_bank,
   output logic              o_swap_pending,
   output logic              o_clear_busy,
   output logic [DROP_W-1:0] o_drop_cnt
);

   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

   vram_state_t       r_state, w_state_nxt;
   logic              r_front_bank, w_front_nxt;
   logic [DROP_W-1:0] r_drop_cnt, w_drop_nxt;
   logic [AW-1:0]     r_clr_cnt, w_cnt_nxt;
   logic              r_q_valid;
   logic              r_swap_pending;
   logic              r_clear_busy;

   logic              w_mem_we;
   logic [AW:0]       w_mem_waddr;
   logic [DW-1:0]     w_mem_wdata;

   // Next-state, bank swap, drop accounting and write-port mux.
   always_comb begin
      w_state_nxt = r_state;
      w_front_nxt = r_front_bank;
      w_drop_nxt  = r_drop_cnt;
      w_cnt_nxt   = r_clr_cnt;
      w_mem_we    = 1'b0;
      w_mem_waddr = {~r_front_bank, i_wr_address};
      w_mem_wdata = i_data;
      case (r_state)
         ST_IDLE: begin
            w_mem_we = i_we;
            if (i_wr_frame_end) begin
               if (i_rd_vblank) w_front_nxt = ~r_front_bank;
               else             w_state_nxt = ST_PENDING;
            end else if (i_clear) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         ST_PENDING: begin
            if (i_wr_frame_end && (r_drop_cnt != DROP_MAX))
               w_drop_nxt = r_drop_cnt + DROP_W'(1);
            if (i_rd_vblank) begin
               w_front_nxt = ~r_front_bank;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {~r_front_bank, r_clr_cnt};
            w_mem_wdata = CLEAR_VAL;
            w_cnt_nxt   = r_clr_cnt + AW'(1);
            if (r_clr_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_front_bank   <= 1'b0;
         r_drop_cnt     <= '0;
         r_clr_cnt      <= '0;
         r_q_valid      <= 1'b0;
         r_swap_pending <= 1'b0;
         r_clear_busy   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_front_bank   <= w_front_nxt;
         r_drop_cnt     <= w_drop_nxt;
         r_clr_cnt      <= w_cnt_nxt;
         r_q_valid      <= i_rd_en;
         r_swap_pending <= (w_state_nxt == ST_PENDING);
         r_clear_busy   <= (w_state_nxt == ST_CLEAR);
      end
   end

   // Read uses the pre-swap front bank in the cycle a swap happens.
   vram_dp1 #(
      .AW (AW + 1),
      .DW (DW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_mem_we),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_re    (i_rd_en),
      .i_raddr ({r_front_bank, i_rd_address}),
      .o_rdata (o_q)
   );

   assign o_q_valid      = r_q_valid;
   assign o_front_bank   = r_front_bank;
   assign o_swap_pending = r_swap_pending;
   assign o_clear_busy   = r_clear_busy;
   assign o_drop_cnt     = r_drop_cnt;

endmodule
